// File: rtl/agent_pkg.sv
// Shared types and constants for the transaction-generating agent.
// Holds the command encoding, FSM states and the Galois LFSR step.
package agent_pkg;

  typedef enum logic [1:0] {
    LLENADO_ALEATORIO    = 2'd0,
    TRANS_ALEATORIA      = 2'd1,
    TRANS_ESPECIFICA     = 2'd2,
    SEC_TRANS_ALEATORIAS = 2'd3
  } instr_e;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_e;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2024;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/trans_fifo_buf.sv
// First-word-fall-through circular FIFO; push is accepted when full only if
// a pop happens in the same cycle. Head reads as zero while empty.
module trans_fifo_buf #(
  parameter int W     = 42,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  output logic          full,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so wrap is free.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/agent_trans_gen.sv
// Command-driven transaction generator: IDLE/GEN FSM, LFSR and remaining
// counter feed a FWFT FIFO drained through a valid/ready port.
module agent_trans_gen
  import agent_pkg::*;
#(
  parameter int          pckg_sz   = 40,
  parameter int          deep_fifo = 8,
  parameter int          drvrs     = 4,
  parameter logic [31:0] SEED      = DEFAULT_SEED,
  localparam int         SRC_W     = $clog2(drvrs),
  localparam int         CNT_W     = $clog2(deep_fifo) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [1:0]         instr_code,
  output logic               instr_ready,
  input  logic [7:0]         num_trans,
  input  logic [SRC_W-1:0]   spec_source,
  input  logic [pckg_sz-1:0] spec_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SRC_W-1:0]   out_source,
  output logic [pckg_sz-1:0] out_data,
  output logic [CNT_W-1:0]   fifo_count,
  output logic               busy
);

  localparam int W = SRC_W + pckg_sz;

  state_e             state_q, state_d;
  instr_e             cmd_q;
  logic [7:0]         remaining_q, remaining_d;
  logic [SRC_W-1:0]   spec_src_q;
  logic [pckg_sz-1:0] spec_data_q;
  logic [31:0]        lfsr_q;
  logic               lfsr_adv;

  logic               push, full, empty, pop_eff;
  logic [W-1:0]       din, dout;
  logic [pckg_sz-1:0] rand_data;
  logic               accept;

  assign instr_ready = (state_q == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state_q != IDLE);
  assign out_valid   = !empty;
  assign pop_eff     = out_ready && !empty;
  assign out_source  = dout[W-1 -: SRC_W];
  assign out_data    = dout[pckg_sz-1:0];

  always_comb begin
    rand_data = '0;
    for (int i = 0; i < pckg_sz; i++) rand_data[i] = lfsr_q[i % 32];
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    push        = 1'b0;
    lfsr_adv    = 1'b0;
    din         = {lfsr_q[SRC_W-1:0], rand_data};
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = GEN;
          case (instr_e'(instr_code))
            SEC_TRANS_ALEATORIAS: remaining_d = num_trans;
            LLENADO_ALEATORIO:    remaining_d = 8'd0;
            default:              remaining_d = 8'd1;
          endcase
        end
      end
      GEN: begin
        if (cmd_q == LLENADO_ALEATORIO) begin
          // Fill stops on reaching full, including when full at accept.
          if (full) begin
            state_d = IDLE;
          end else begin
            push     = 1'b1;
            lfsr_adv = 1'b1;
            if (fifo_count == CNT_W'(deep_fifo - 1) && !pop_eff) state_d = IDLE;
          end
        end else if (remaining_q == 8'd0) begin
          state_d = IDLE;
        end else if (!full || pop_eff) begin
          push        = 1'b1;
          remaining_d = remaining_q - 8'd1;
          if (cmd_q == TRANS_ESPECIFICA) din = {spec_src_q, spec_data_q};
          else                           lfsr_adv = 1'b1;
          if (remaining_q == 8'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= LLENADO_ALEATORIO;
      remaining_q <= '0;
      spec_src_q  <= '0;
      spec_data_q <= '0;
      lfsr_q      <= SEED;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      if (accept) begin
        cmd_q       <= instr_e'(instr_code);
        spec_src_q  <= spec_source;
        spec_data_q <= spec_data;
      end
      if (lfsr_adv) lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  trans_fifo_buf #(.W(W), .DEPTH(deep_fifo)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .full  (full),
    .pop   (pop_eff),
    .dout  (dout),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_agent_trans_gen.sv
// Scoreboard bench for agent_trans_gen: stimulus pushes expected entries,
// a negedge monitor pops and compares whenever the driver accepts the head.
module tb_agent_trans_gen;
  import agent_pkg::*;

  localparam int          PW    = 40;
  localparam int          DEPTH = 8;
  localparam int          SW    = 2;
  localparam logic [31:0] SEED  = 32'hACE1_2024;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [1:0]    instr_code;
  logic          instr_ready;
  logic [7:0]    num_trans;
  logic [SW-1:0] spec_source;
  logic [PW-1:0] spec_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_source;
  logic [PW-1:0] out_data;
  logic [3:0]    fifo_count;
  logic          busy;

  logic [SW+PW-1:0] exp_q[$];
  logic [31:0]      lfsr_m;
  int               vectors = 0;
  int               miscompares = 0;
  int               pops = 0;

  agent_trans_gen #(.pckg_sz(PW), .deep_fifo(DEPTH), .drvrs(4), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_code(instr_code),
    .instr_ready(instr_ready), .num_trans(num_trans), .spec_source(spec_source),
    .spec_data(spec_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_source(out_source), .out_data(out_data), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Independent golden Galois LFSR: bit 31 takes the feedback, taps at 21, 1, 0.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] n;
    n = {s[0], s[31:1]};
    n[21] = n[21] ^ s[0];
    n[1]  = n[1] ^ s[0];
    n[0]  = n[0] ^ s[0];
    return n;
  endfunction

  function automatic logic [SW+PW-1:0] model_entry(input logic [31:0] s);
    return {s[1:0], s[7:0], s};
  endfunction

  task automatic push_rand();
    exp_q.push_back(model_entry(lfsr_m));
    lfsr_m = model_step(lfsr_m);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {out_source, out_data}, 64'hDEAD);
      end else begin
        check("pop_entry", {out_source, out_data}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] code, input logic [7:0] n,
                       input logic [SW-1:0] src, input logic [PW-1:0] data);
    int fill;
    for (int i = 0; i < 100 && !instr_ready; i++) tick();
    check("instr_ready_wait", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr_code  = code;
    num_trans   = n;
    spec_source = src;
    spec_data   = data;
    tick();
    instr_valid = 1'b0;
    case (instr_e'(code))
      TRANS_ALEATORIA:      push_rand();
      TRANS_ESPECIFICA:     exp_q.push_back({src, data});
      SEC_TRANS_ALEATORIAS: for (int i = 0; i < n; i++) push_rand();
      default: begin
        fill = DEPTH - exp_q.size();
        for (int i = 0; i < fill; i++) push_rand();
      end
    endcase
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    out_ready = 1'b0;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0;
    reset = 1'b1; instr_valid = 1'b0; instr_code = '0; num_trans = '0;
    spec_source = '0; spec_data = '0; out_ready = 1'b0;
    lfsr_m = SEED;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_instr_ready", instr_ready, 1'b0);
    check("rst_out_data", {out_source, out_data}, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", instr_ready, 1'b1);

    // 1: specific transaction, two-cycle latency to out_valid.
    out_ready = 1'b1;
    issue(TRANS_ESPECIFICA, 8'd0, 2'd2, 40'h12_3456_789A);
    check("t1_valid_at_accept", out_valid, 1'b0);
    check("t1_busy", busy, 1'b1);
    tick();
    check("t1_valid", out_valid, 1'b1);
    check("t1_source", out_source, 2'd2);
    check("t1_data", out_data, 40'h12_3456_789A);
    tick();
    check("t1_empty", out_valid, 1'b0);
    check("t1_idle", busy, 1'b0);
    out_ready = 1'b0;

    // 2: random transactions against hand-computed LFSR states.
    issue(TRANS_ALEATORIA, 8'd0, '0, '0);
    wait_idle();
    check("t2_data0", out_data, 40'h24_ACE1_2024);
    check("t2_src0", out_source, 2'd0);
    drain();
    issue(TRANS_ALEATORIA, 8'd0, '0, '0);
    wait_idle();
    check("t2_data1", out_data, 40'h12_5670_9012);
    check("t2_src1", out_source, 2'd2);
    drain();

    // 3: fill to full, then a second fill pushes nothing.
    issue(LLENADO_ALEATORIO, 8'd0, '0, '0);
    wait_idle();
    check("t3_count_full", fifo_count, DEPTH);
    issue(LLENADO_ALEATORIO, 8'd0, '0, '0);
    repeat (3) tick();
    check("t3_refill_idle", busy, 1'b0);
    check("t3_refill_count", fifo_count, DEPTH);

    // 5: push and pop together while full keep count and order.
    issue(TRANS_ESPECIFICA, 8'd0, 2'd3, 40'hAB_CDEF_0123);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_count_stays", fifo_count, DEPTH);
    check("t5_idle", busy, 1'b0);
    drain();
    check("t5_drained", fifo_count, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t5_pop_empty_count", fifo_count, 0);
    check("t5_pop_empty_valid", out_valid, 1'b0);
    check("t5_pop_empty_data", {out_source, out_data}, 0);

    // 4: sequence of 20 with a randomly throttled driver.
    p0 = pops;
    issue(SEC_TRANS_ALEATORIAS, 8'd20, '0, '0);
    for (int i = 0; i < 600 && (exp_q.size() != 0 || busy); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b0;
    check("t4_queue_empty", exp_q.size(), 0);
    check("t4_pop_count", pops - p0, 20);
    check("t4_idle", busy, 1'b0);
    issue(SEC_TRANS_ALEATORIAS, 8'd0, '0, '0);
    check("t4_zero_busy", busy, 1'b1);
    tick();
    check("t4_zero_idle", busy, 1'b0);
    check("t4_zero_nothing", out_valid, 1'b0);

    // 6: reset in the middle of a sequence.
    issue(SEC_TRANS_ALEATORIAS, 8'd10, '0, '0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("t6_ready_in_rst", instr_ready, 1'b0);
    tick();
    check("t6_valid", out_valid, 1'b0);
    check("t6_count", fifo_count, 0);
    check("t6_busy", busy, 1'b0);
    exp_q.delete();
    lfsr_m = SEED;
    reset = 1'b0;
    #1;
    check("t6_ready", instr_ready, 1'b1);
    issue(TRANS_ALEATORIA, 8'd0, '0, '0);
    wait_idle();
    check("t6_seed_data", out_data, 40'h24_ACE1_2024);
    check("t6_seed_src", out_source, 2'd0);
    drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
